onchip_memory2_arbiter: RTL and testbench

- Two-requester Avalon-MM arbiter that shares the single-port 8192 x 32 on-chip RAM (onchip_memory2) between requester 0 (Nios II data master) and requester 1 (CAN frame buffer DMA).
- Round-robin grant each cycle with waitrequest back-pressure.
- Routes the RAM's 1-cycle read data back to the owning requester with readdatavalid.
- Sits between the system interconnect and the RAM's s1 port.

---
 rtl/onchip_mem_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/onchip_memory2_arbiter.sv | 97 +++++++++
 tb/tb_onchip_memory2_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared widths and requester identifiers for the on-chip RAM arbiter.
package onchip_mem_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_CPU = 1'b0;
  localparam req_idx_t REQ_DMA = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, last winner registered.
module rr_arbiter2
  import onchip_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output req_idx_t   gnt_idx
);

  req_idx_t last_grant;

  always_comb begin
    gnt_idx = REQ_CPU;
    gnt     = 2'b00;
    case (req)
      2'b01:   gnt_idx = REQ_CPU;
      2'b10:   gnt_idx = REQ_DMA;
      2'b11:   gnt_idx = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
      default: gnt_idx = REQ_CPU;
    endcase
    if (|req) gnt = (gnt_idx == REQ_DMA) ? 2'b10 : 2'b01;
  end

  // Reset to the DMA side so the CPU wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (reset)        last_grant <= REQ_DMA;
    else if (advance) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/onchip_memory2_arbiter.sv
// Shares the single-port on-chip RAM between the Nios II data master and the
// CAN DMA; one access per cycle, read data returned one cycle after accept.
module onchip_memory2_arbiter #(
  parameter int ADDR_W = onchip_mem_pkg::ADDR_W,
  parameter int DATA_W = onchip_mem_pkg::DATA_W,
  parameter int BE_W   = onchip_mem_pkg::BE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [BE_W-1:0]   r0_byteenable,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [BE_W-1:0]   r1_byteenable,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              err_rw
);

  import onchip_mem_pkg::*;

  logic [1:0] req;
  logic [1:0] gnt;
  req_idx_t   gnt_idx;
  logic       issue_read;
  logic       rd_pending;
  req_idx_t   rd_owner;

  assign req = {r1_read | r1_write, r0_read | r0_write} & {2{~reset}};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (|req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Idle cycles present requester 0's fields so the RAM inputs stay deterministic.
  always_comb begin
    mem_address    = r0_address;
    mem_byteenable = r0_byteenable;
    mem_writedata  = r0_writedata;
    mem_write      = 1'b0;
    issue_read     = 1'b0;
    if (gnt[1]) begin
      mem_address    = r1_address;
      mem_byteenable = r1_byteenable;
      mem_writedata  = r1_writedata;
      mem_write      = r1_write;
      issue_read     = r1_read & ~r1_write;
    end else if (gnt[0]) begin
      mem_write      = r0_write;
      issue_read     = r0_read & ~r0_write;
    end
  end

  assign mem_chipselect = |gnt;
  assign mem_clken      = ~reset;
  assign r0_waitrequest = ~gnt[0];
  assign r1_waitrequest = ~gnt[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_owner   <= REQ_CPU;
      err_rw     <= 1'b0;
    end else begin
      rd_pending <= issue_read;
      if (issue_read) rd_owner <= gnt_idx;
      if ((r0_read & r0_write) | (r1_read & r1_write)) err_rw <= 1'b1;
    end
  end

  assign r0_readdata      = mem_readdata;
  assign r1_readdata      = mem_readdata;
  assign r0_readdatavalid = rd_pending & ~reset & (rd_owner == REQ_CPU);
  assign r1_readdatavalid = rd_pending & ~reset & (rd_owner == REQ_DMA);

endmodule

// File: tb/tb_onchip_memory2_arbiter.sv
// Directed and randomized bench for the on-chip RAM arbiter with a RAM model.
module tb_onchip_memory2_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] r0_address, r1_address, mem_address;
  logic [BW-1:0] r0_byteenable, r1_byteenable, mem_byteenable;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [DW-1:0] r0_writedata, r1_writedata, mem_writedata;
  logic          r0_waitrequest, r1_waitrequest;
  logic [DW-1:0] r0_readdata, r1_readdata, mem_readdata;
  logic          r0_readdatavalid, r1_readdatavalid;
  logic          mem_chipselect, mem_write, mem_clken, err_rw;

  onchip_memory2_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read),
    .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read),
    .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_rw(err_rw)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // RAM stand-in: registered read, write committed at the accepting edge.
  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata     <= ram[mem_address];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: who was served last, what read is in flight.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  int            m_last;
  bit            m_pend;
  int            m_owner;
  logic [DW-1:0] m_data;
  bit            m_err;
  bit            acc0, acc1;

  task automatic cycle();
    int            win;
    bit            q0, q1, wr, rd;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    @(negedge clk);
    if (reset) begin
      check_eq("rst_wait0", r0_waitrequest, 1'b1);
      check_eq("rst_wait1", r1_waitrequest, 1'b1);
      check_eq("rst_cs", mem_chipselect, 1'b0);
      check_eq("rst_mwr", mem_write, 1'b0);
      check_eq("rst_rdv", {r1_readdatavalid, r0_readdatavalid}, 2'b00);
      m_last = 1; m_pend = 0; m_owner = 0; m_err = 0; acc0 = 0; acc1 = 0;
    end else begin
      q0 = r0_read | r0_write;
      q1 = r1_read | r1_write;
      if (q0 && q1)  win = 1 - m_last;
      else if (q0)   win = 0;
      else if (q1)   win = 1;
      else           win = -1;
      check_eq("wait0", r0_waitrequest, win != 0);
      check_eq("wait1", r1_waitrequest, win != 1);
      check_eq("cs", mem_chipselect, win >= 0);
      a  = (win == 1) ? r1_address : r0_address;
      be = (win == 1) ? r1_byteenable : r0_byteenable;
      wd = (win == 1) ? r1_writedata : r0_writedata;
      wr = (win == 1) ? r1_write : (win == 0) ? r0_write : 1'b0;
      rd = (win == 1) ? r1_read : (win == 0) ? r0_read : 1'b0;
      check_eq("maddr", mem_address, a);
      check_eq("mwr", mem_write, wr);
      if (wr) begin
        check_eq("mbe", mem_byteenable, be);
        check_eq("mwd", mem_writedata, wd);
      end
      check_eq("rdv0", r0_readdatavalid, m_pend && m_owner == 0);
      check_eq("rdv1", r1_readdatavalid, m_pend && m_owner == 1);
      if (m_pend) begin
        check_eq("rdata0", r0_readdata, m_data);
        check_eq("rdata1", r1_readdata, m_data);
      end
      check_eq("err_rw", err_rw, m_err);
      acc0 = (win == 0);
      acc1 = (win == 1);
      m_pend = 0;
      if (win >= 0) begin
        m_last = win;
        if (wr) ref_mem[a] = merge(ref_mem[a], wd, be);
        else if (rd) begin
          m_pend = 1; m_owner = win; m_data = ref_mem[a];
        end
      end
      if ((r0_read && r0_write) || (r1_read && r1_write)) m_err = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int who, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (who == 0) begin
      r0_read = rd; r0_write = wr; r0_address = a; r0_byteenable = be; r0_writedata = d;
    end else begin
      r1_read = rd; r1_write = wr; r1_address = a; r1_byteenable = be; r1_writedata = d;
    end
  endtask

  task automatic idle_all();
    drv(0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, '0, '0, '0);
  endtask

  task automatic rand_req(input int who);
    int            r;
    logic [AW-1:0] a;
    r = $urandom_range(0, 99);
    a = ($urandom_range(0, 9) == 0) ? 13'h1FFF : AW'($urandom_range(0, 7));
    if (r < 35)      drv(who, 0, 0, a, '0, '0);
    else if (r < 65) drv(who, 1, 0, a, BW'($urandom_range(0, 15)), $urandom);
    else if (r < 96) drv(who, 0, 1, a, BW'($urandom_range(0, 15)), $urandom);
    else             drv(who, 1, 1, a, BW'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    bit h0, h1;
    reset = 1'b1;
    idle_all();
    repeat (2) cycle();
    reset = 1'b0;
    repeat (5) cycle();

    // Write then read back the same word on consecutive cycles.
    drv(0, 0, 1, 13'h0010, 4'hF, 32'hDEADBEEF); cycle();
    drv(0, 1, 0, 13'h0010, 4'hF, 32'h0);        cycle();
    idle_all();
    check_eq("raw_rdv0", r0_readdatavalid, 1'b1);
    check_eq("raw_rdv1", r1_readdatavalid, 1'b0);
    check_eq("raw_data", r0_readdata, 32'hDEADBEEF);
    cycle();

    // Contended writes, then 8 cycles of contended reads.
    drv(0, 0, 1, 13'h0001, 4'hF, 32'hA5A5A5A5);
    drv(1, 0, 1, 13'h1FFF, 4'hF, 32'h12345678);
    repeat (2) cycle();
    drv(0, 1, 0, 13'h0001, 4'hF, 32'h0);
    drv(1, 1, 0, 13'h1FFF, 4'hF, 32'h0);
    repeat (8) cycle();
    idle_all(); cycle();

    // Partial byte-enable write over a full word.
    drv(1, 0, 1, 13'h0100, 4'hF, 32'hFFFFFFFF); cycle();
    drv(1, 0, 1, 13'h0100, 4'h3, 32'h11223344); cycle();
    drv(1, 1, 0, 13'h0100, 4'hF, 32'h0);        cycle();
    idle_all();
    check_eq("be_merge", r1_readdata, 32'hFFFF3344);
    cycle();

    // Reset while a read is outstanding.
    drv(1, 1, 0, 13'h0100, 4'hF, 32'h0); cycle();
    idle_all(); reset = 1'b1; cycle();
    check_eq("rst_drop_rdv1", r1_readdatavalid, 1'b0);
    reset = 1'b0;
    drv(0, 1, 0, 13'h0001, 4'hF, 32'h0);
    drv(1, 1, 0, 13'h1FFF, 4'hF, 32'h0);
    #1;
    check_eq("rst_first_r0", r0_waitrequest, 1'b0);
    check_eq("rst_first_r1", r1_waitrequest, 1'b1);
    cycle();
    idle_all(); cycle();

    // Read and write together: write wins, sticky error.
    drv(0, 1, 1, 13'h0020, 4'hF, 32'h5A5A5A5A); cycle();
    idle_all(); cycle();
    check_eq("rw_no_rdv", r0_readdatavalid, 1'b0);
    check_eq("err_set", err_rw, 1'b1);
    repeat (3) cycle();
    drv(0, 1, 0, 13'h0020, 4'hF, 32'h0); cycle();
    idle_all();
    check_eq("rw_data", r0_readdata, 32'h5A5A5A5A);
    check_eq("err_sticky", err_rw, 1'b1);
    cycle();

    // Randomized traffic obeying the hold-while-waiting rule.
    h0 = 0; h1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1; idle_all(); h0 = 0; h1 = 0;
      end else begin
        reset = 1'b0;
        if (!h0) rand_req(0);
        if (!h1) rand_req(1);
      end
      cycle();
      h0 = !reset && (r0_read || r0_write) && !acc0;
      h1 = !reset && (r1_read || r1_write) && !acc1;
    end

    reset = 1'b1; idle_all(); cycle();
    reset = 1'b0; cycle();
    check_eq("err_cleared", err_rw, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
